sobel_edge_top: RTL and testbench
=================================

SOBEL_EDGE_TOP -- requirements
Module: sobel_edge_top

Interface
REQ-001 SHALL have parameter IMG_W, default 256, meaning image width in pixels; must be a power of 2.
REQ-002 SHALL have parameter IMG_H, default 256, meaning image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 16, meaning RAM address width; IMG_W*IMG_H <= 2^ADDR_W.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to process the image.
REQ-007 SHALL have port ram_rd_valid_o, output, 1 bit: read enable to the source RAM, which holds the Gaussian-filtered image.
REQ-008 SHALL have port ram_rd_addr_o, output, ADDR_W bits: source read address, raster order {row,col}.
REQ-009 SHALL have port ram_valid_in, input, 1 bit: source read data valid.
REQ-010 SHALL have port ram_data_in, input, 8 bits: source pixel.
REQ-011 SHALL have port ram_wr_valid_o, output, 1 bit: destination write enable.
REQ-012 SHALL have port ram_wr_addr_o, output, ADDR_W bits: destination write address.
REQ-013 SHALL have port ram_wr_data_o, output, 8 bits: edge magnitude.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM IDLE -> READ -> FLUSH -> FIN -> IDLE; start is honoured only in IDLE and ignored elsewhere.
REQ-016 SHALL in READ assert ram_rd_valid_o every cycle, with addresses 0..IMG_W*IMG_H-1 incrementing by 1, then deassert it.
REQ-017 SHALL consume pixels only on ram_valid_in, tolerate arbitrary gaps, and keep no fixed-latency assumption.
REQ-018 SHALL hold two IMG_W x 8 line buffers plus a 3x3 window register, advancing one pixel per ram_valid_in.
REQ-019 SHALL, on the arrival of input index i >= IMG_W+1, produce output for center index c = i-(IMG_W+1).
REQ-020 SHALL produce no write for the first IMG_W+1 inputs.
REQ-021 SHALL assert ram_wr_valid_o exactly 2 cycles after the ram_valid_in cycle that delivers index i, with ram_wr_addr_o = c.
REQ-022 SHALL compute Gx = (p02+2p12+p22)-(p00+2p10+p20) and Gy = (p20+2p21+p22)-(p00+2p01+p02) as 11-bit signed values; no overflow is permitted.
REQ-023 SHALL compute mag = |Gx|+|Gy| as 11-bit unsigned, with output = 255 if mag > 255, else mag[7:0].
REQ-024 SHALL output 0 for border centers (row 0, row IMG_H-1, col 0, col IMG_W-1); window wrap across rows at borders is don't-care.
REQ-025 SHALL enter FLUSH after the last input is consumed and write 0 to the remaining IMG_W+1 addresses, one per cycle, in ascending order.
REQ-026 SHALL enter FIN after the final write, assert done for exactly 1 cycle, then return to IDLE.
REQ-027 SHALL write every destination address exactly once per run, all in ascending order.
REQ-028 SHALL allow a new start in IDLE the cycle after done; line buffer contents need no clearing between runs.

Reset
REQ-029 SHALL, on rst high at any time including mid-run, drive the FSM to IDLE and force ram_rd_valid_o, ram_wr_valid_o and done to 0, and ram_rd_addr_o, ram_wr_addr_o and ram_wr_data_o to 0, and clear all counters, asynchronously.
REQ-030 SHALL, after rst is released, issue no reads or writes until the next start.

Verification
REQ-031 SHALL verify a constant image (all 100) -> all 65536 outputs 0, done pulses once, and there are exactly 65536 writes.
REQ-032 SHALL verify a vertical step (cols 0..127 = 0, cols 128..255 = 255) -> interior cols 127 and 128 = 255, all other outputs 0.
REQ-033 SHALL verify a horizontal ramp (pixel = col) -> interior outputs 8 and border outputs 0.
REQ-034 SHALL verify a checkerboard of 0/255 -> every interior output saturates to 255, and a scoreboard shows no 11-bit overflow.
REQ-035 SHALL verify rst asserted at read address 30000, then a new start -> outputs idle immediately, the second run's output is correct, and a second start pulse issued during READ is ignored.
REQ-036 SHALL verify ram_valid_in with random 1-3 cycle gaps (source RAM stalled) -> output identical to the gap-free run, and ram_wr_valid_o is exactly 2 cycles after each consumed valid.

Source files
------------

// File: rtl/sobel_edge_top.sv
// Sobel edge magnitude over a raster image streamed from a source RAM.
// Ports: clk/rst/start control, RAM read request/response, RAM write, done pulse.
module sobel_edge_top #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_rd_valid_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic              ram_valid_in,
  input  logic [7:0]        ram_data_in,
  output logic              ram_wr_valid_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [7:0]        ram_wr_data_o,
  output logic              done
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] LAG_A  = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] FL_A0  = ADDR_W'(NPIX - IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_L  = ADDR_W'(IMG_H - 1);
  localparam logic [XW-1:0]     COL_L  = XW'(IMG_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_FIN} state_t;

  state_t            r_state;
  logic              r_rd_valid;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_in_cnt;
  logic [ADDR_W-1:0] r_fl_addr;
  logic              r_s1_vld;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_s1_bdr;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_done;

  logic [7:0] r_lb0 [IMG_W];
  logic [7:0] r_lb1 [IMG_W];
  // [row][col]; row 0 is the oldest line, col 2 the newest column
  logic [7:0] r_win [3][3];

  logic              w_take;
  logic [XW-1:0]     w_col;
  logic [ADDR_W-1:0] w_c;
  logic [ADDR_W-1:0] w_crow;
  logic [XW-1:0]     w_ccol;
  logic              w_bdr;
  logic signed [10:0] w_gx;
  logic signed [10:0] w_gy;
  logic [10:0]       w_ax;
  logic [10:0]       w_ay;
  logic [10:0]       w_mag;
  logic [7:0]        w_pix;

  function automatic logic signed [10:0] px(input logic [7:0] v);
    return signed'({3'b000, v});
  endfunction

  assign w_take = (r_state == S_READ) && ram_valid_in;
  assign w_col  = r_in_cnt[XW-1:0];
  // center pixel trails the arriving one by one line plus one pixel
  assign w_c    = r_in_cnt - LAG_A;
  assign w_crow = w_c >> XW;
  assign w_ccol = w_c[XW-1:0];
  assign w_bdr  = (w_crow == '0) || (w_crow == ROW_L) ||
                  (w_ccol == '0) || (w_ccol == COL_L);

  assign w_gx = (px(r_win[0][2]) + (px(r_win[1][2]) <<< 1) + px(r_win[2][2]))
              - (px(r_win[0][0]) + (px(r_win[1][0]) <<< 1) + px(r_win[2][0]));
  assign w_gy = (px(r_win[2][0]) + (px(r_win[2][1]) <<< 1) + px(r_win[2][2]))
              - (px(r_win[0][0]) + (px(r_win[0][1]) <<< 1) + px(r_win[0][2]));
  assign w_ax  = w_gx[10] ? $unsigned(-w_gx) : $unsigned(w_gx);
  assign w_ay  = w_gy[10] ? $unsigned(-w_gy) : $unsigned(w_gy);
  assign w_mag = w_ax + w_ay;
  assign w_pix = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= ram_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_in_cnt   <= '0;
      r_fl_addr  <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_bdr   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else begin
      r_done     <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_wr_valid <= r_s1_vld;
      if (r_s1_vld) begin
        r_wr_addr <= r_s1_addr;
        r_wr_data <= r_s1_bdr ? 8'd0 : w_pix;
      end
      if (w_take) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb1[w_col];
        r_win[1][2] <= r_lb0[w_col];
        r_win[2][2] <= ram_data_in;
        r_in_cnt <= (r_in_cnt == LAST_A) ? '0 : r_in_cnt + 1'b1;
        if (r_in_cnt >= LAG_A) begin
          r_s1_vld  <= 1'b1;
          r_s1_addr <= w_c;
          r_s1_bdr  <= w_bdr;
        end
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_READ;
            r_rd_valid <= 1'b1;
            r_rd_addr  <= '0;
          end
        end
        S_READ: begin
          if (r_rd_valid) begin
            if (r_rd_addr == LAST_A) r_rd_valid <= 1'b0;
            else r_rd_addr <= r_rd_addr + 1'b1;
          end
          if (w_take && (r_in_cnt == LAST_A)) begin
            r_state   <= S_FLUSH;
            r_fl_addr <= FL_A0;
          end
        end
        S_FLUSH: begin
          // tail addresses ride the same pipe, forced to zero
          r_s1_vld  <= 1'b1;
          r_s1_addr <= r_fl_addr;
          r_s1_bdr  <= 1'b1;
          r_fl_addr <= r_fl_addr + 1'b1;
          if (r_fl_addr == LAST_A) r_state <= S_FIN;
        end
        S_FIN: begin
          if (!r_s1_vld) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_rd_valid_o = r_rd_valid;
  assign ram_rd_addr_o  = r_rd_addr;
  assign ram_wr_valid_o = r_wr_valid;
  assign ram_wr_addr_o  = r_wr_addr;
  assign ram_wr_data_o  = r_wr_data;
  assign done           = r_done;
endmodule

// File: tb/tb_sobel_edge_top.sv
// Directed bench for sobel_edge_top on a 16x8 image with a RAM model.
// Ports: all DUT ports driven/observed; summary line at the end.
module tb_sobel_edge_top;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int AW = 8;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ram_rd_valid_o;
  logic [AW-1:0] ram_rd_addr_o;
  logic          ram_valid_in;
  logic [7:0]    ram_data_in;
  logic          ram_wr_valid_o;
  logic [AW-1:0] ram_wr_addr_o;
  logic [7:0]    ram_wr_data_o;
  logic          done;

  always #5 clk = ~clk;

  sobel_edge_top #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_rd_valid_o(ram_rd_valid_o), .ram_rd_addr_o(ram_rd_addr_o),
    .ram_valid_in(ram_valid_in), .ram_data_in(ram_data_in),
    .ram_wr_valid_o(ram_wr_valid_o), .ram_wr_addr_o(ram_wr_addr_o),
    .ram_wr_data_o(ram_wr_data_o), .done(done)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] src [N];
  int dst [N];
  int expv [N];
  int rq [$];
  int vq [$];
  int cyc = 0;
  int gap_left = 0;
  int nin, nrd, rd_err, nwr, ord_err, lat_err, done_cnt, exp_wa, exp_ra;
  bit gap_mode = 1'b0;

  task automatic chk(string tag, int obs, int want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic chk_idle(string tag);
    chk({tag, " rd_valid"}, int'(ram_rd_valid_o), 0);
    chk({tag, " wr_valid"}, int'(ram_wr_valid_o), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " rd_addr"}, int'(ram_rd_addr_o), 0);
    chk({tag, " wr_addr"}, int'(ram_wr_addr_o), 0);
    chk({tag, " wr_data"}, int'(ram_wr_data_o), 0);
  endtask

  // one cycle: observe DUT at negedge, then play the source RAM
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ram_rd_valid_o) begin
      if (int'(ram_rd_addr_o) != exp_ra) rd_err++;
      exp_ra = int'(ram_rd_addr_o) + 1;
      nrd++;
      rq.push_back(int'(ram_rd_addr_o));
    end
    if (ram_wr_valid_o) begin
      int a = int'(ram_wr_addr_o);
      if (a != exp_wa) ord_err++;
      exp_wa = a + 1;
      nwr++;
      if (a < N) dst[a] = int'(ram_wr_data_o);
      if (a < N - W - 1) begin
        if (vq.size() == 0) lat_err++;
        else if (cyc - vq.pop_front() != 2) lat_err++;
      end
    end
    if (done) done_cnt++;
    ram_valid_in = 1'b0;
    ram_data_in = 8'h00;
    if (gap_left > 0) gap_left--;
    else if (rq.size() > 0) begin
      int a = rq.pop_front();
      ram_valid_in = 1'b1;
      ram_data_in = src[a];
      if (nin >= W + 1) vq.push_back(cyc);
      nin++;
      if (gap_mode) gap_left = $urandom_range(1, 3);
    end
  endtask

  function automatic int pix(int p, int r, int c);
    case (p)
      0: return 100;
      1: return (c >= W / 2) ? 255 : 0;
      2: return c;
      3: return ((((r >> 1) + (c >> 1)) % 2) != 0) ? 255 : 0;
      4: return 28 * r + 3 * c;
      default: return 29 * r + 3 * c;
    endcase
  endfunction

  // hand-derived: ramp Gx=8, 2x2 checker |Gx|=|Gy|=510,
  // diag 28r+3c gives 224+24=248, 29r+3c gives 256 -> 255
  function automatic int expo(int p, int r, int c);
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    case (p)
      0: return 0;
      1: return (c == W / 2 - 1 || c == W / 2) ? 255 : 0;
      2: return 8;
      3: return 255;
      4: return 248;
      default: return 255;
    endcase
  endfunction

  task automatic prep(int p, bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        src[r * W + c] = 8'(pix(p, r, c));
        expv[r * W + c] = expo(p, r, c);
        dst[r * W + c] = -1;
      end
    nin = 0; nrd = 0; rd_err = 0; nwr = 0; ord_err = 0;
    lat_err = 0; done_cnt = 0; exp_wa = 0; exp_ra = 0; gap_left = 0;
    rq.delete();
    vq.delete();
    gap_mode = gaps;
  endtask

  task automatic run(string tag, int p, bit gaps, int restart_at);
    bit fin = 1'b0;
    int mism = 0;
    prep(p, gaps);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8 * N + 200 && !fin; k++) begin
      if (restart_at >= 0 && ram_rd_valid_o &&
          int'(ram_rd_addr_o) == restart_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end else tick();
      if (done) fin = 1'b1;
    end
    chk({tag, " finished"}, int'(fin), 1);
    tick();
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " reads"}, nrd, N);
    chk({tag, " read_order"}, rd_err, 0);
    chk({tag, " writes"}, nwr, N);
    chk({tag, " write_order"}, ord_err, 0);
    chk({tag, " latency"}, lat_err, 0);
    for (int i = 0; i < N; i++)
      if (dst[i] != expv[i]) mism++;
    chk({tag, " pixel_mismatches"}, mism, 0);
    chk({tag, " px_r3_c7"}, dst[3 * W + 7], expv[3 * W + 7]);
    chk({tag, " px_r2_c8"}, dst[2 * W + 8], expv[2 * W + 8]);
    chk({tag, " px_last"}, dst[N - 1], 0);
  endtask

  initial begin
    bit hit;
    int quiet;
    rst = 1'b1;
    start = 1'b0;
    ram_valid_in = 1'b0;
    ram_data_in = 8'h00;
    prep(0, 1'b0);
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    quiet = 0;
    repeat (6) begin
      tick();
      if (ram_rd_valid_o || ram_wr_valid_o || done) quiet++;
    end
    chk("post_reset_quiet", quiet, 0);

    run("const", 0, 1'b0, -1);
    run("vstep", 1, 1'b0, -1);
    run("hramp", 2, 1'b0, -1);
    run("checker", 3, 1'b0, -1);
    run("diag248", 4, 1'b0, -1);
    run("diag255", 5, 1'b0, -1);

    prep(2, 1'b0);
    hit = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4 * N && !hit; k++) begin
      tick();
      if (ram_rd_valid_o && int'(ram_rd_addr_o) == 60) hit = 1'b1;
    end
    chk("midrun_reached", int'(hit), 1);
    chk("midrun_writing", int'(ram_wr_valid_o), 1);
    rst = 1'b1;
    #1;
    chk_idle("midrun_rst");
    tick();
    tick();
    rst = 1'b0;
    rq.delete();
    vq.delete();
    quiet = 0;
    repeat (6) begin
      tick();
      if (ram_rd_valid_o || ram_wr_valid_o || done) quiet++;
    end
    chk("midrun_quiet", quiet, 0);

    run("restart", 2, 1'b0, 40);
    run("vstep_gap", 1, 1'b1, -1);
    run("checker_gap", 3, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
